sensor_detect_scheduler: RTL

Round-robin scheduler that shares the single anomaly-detector core between NUM_CH sensor channels. It grants one pending channel at a time and latches that channel's sample. It drives the detector's valid/data inputs, waits for the detector's done pulse (with timeout), and returns a per-channel acknowledge plus a tagged result. It sits between the sensor front-end buffers and the detector core.

---
 rtl/sensor_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/sensor_detect_scheduler.sv | 86 ++++++++
 3 files changed

// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: shared state encoding and default widths for the sensor detect scheduler
package sensor_sched_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;
  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int ANOM_W = 16;
  localparam int TOUT_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = |req;
    // scan from the farthest offset down so the nearest request wins last
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/sensor_detect_scheduler.sv
// sensor_detect_scheduler: round-robin sharing of one anomaly detector across sensor channels
module sensor_detect_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW = $clog2(NUM_CH),
  localparam int TW = $clog2(TIMEOUT) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        det_data,
  output logic                     det_valid,
  input  logic                     det_done,
  input  logic                     det_anomaly,
  output logic                     res_valid,
  output logic [IW-1:0]            res_chan,
  output logic                     res_anomaly,
  output logic                     res_timeout,
  output logic [ANOM_W-1:0]        anomaly_count,
  output logic [TOUT_W-1:0]        timeout_count
);
  logic [1:0] state, next;
  logic [NUM_CH-1:0] gnt, gnt_q;
  logic [IW-1:0] idx, idx_q, rr_ptr;
  logic any, expire;
  logic [DATA_W-1:0] data_q;
  logic [TW-1:0] timer;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req(ch_valid),
    .ptr(rr_ptr),
    .grant(gnt),
    .idx(idx),
    .any(any)
  );

  // timer is 0 in the first WAIT cycle, so this marks the cycle TIMEOUT-1 after ISSUE
  assign expire = timer == TW'(TIMEOUT - 2);
  assign det_valid = state == S_ISSUE;
  assign res_valid = state == S_REPORT;
  assign ch_ack = res_valid ? gnt_q : '0;
  assign det_data = data_q;

  always_comb
    next = state == S_IDLE ? (any ? S_ISSUE : S_IDLE) :
           state == S_ISSUE ? S_WAIT :
           state == S_WAIT ? ((det_done || expire) ? S_REPORT : S_WAIT) : S_IDLE;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      rr_ptr <= '0;
      data_q <= '0;
      timer <= '0;
      res_chan <= '0;
      res_anomaly <= 1'b0;
      res_timeout <= 1'b0;
      anomaly_count <= '0;
      timeout_count <= '0;
    end else begin
      state <= next;
      timer <= state == S_WAIT ? timer + 1'b1 : '0;
      if (state == S_IDLE && any) begin
        gnt_q <= gnt;
        idx_q <= idx;
        data_q <= ch_data[idx*DATA_W +: DATA_W];
      end
      if (state == S_WAIT && (det_done || expire)) begin
        res_chan <= idx_q;
        res_anomaly <= det_done && det_anomaly;
        res_timeout <= !det_done;
      end
      if (state == S_REPORT) begin
        rr_ptr <= idx_q == IW'(NUM_CH - 1) ? '0 : idx_q + 1'b1;
        if (res_anomaly && !(&anomaly_count)) anomaly_count <= anomaly_count + 1'b1;
        if (res_timeout && !(&timeout_count)) timeout_count <= timeout_count + 1'b1;
      end
    end
endmodule
